bit_pattern_detector: RTL and testbench



---
 rtl/bpd_pkg.sv | 15 +
 rtl/sat_counter.sv | 28 ++
 rtl/bit_pattern_detector.sv | 64 ++++++
 tb/tb_bit_pattern_detector.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bpd_pkg.sv
// Shared types and constants for the serial 1011 pattern detector.
package bpd_pkg;

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1011;
    localparam int         PAT_LEN = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides counting.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    // clr acts even while en is low, and beats a same-edge increment
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && inc) begin
            q <= sat_inc(q);
        end
    end

endmodule

// File: rtl/bit_pattern_detector.sv
// Moore FSM detecting overlapping 1011 on the sampled latch output, with
// a one-cycle detect pulse, saturating match count and 4-bit history window.
module bit_pattern_detector
    import bpd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             en,
    input  logic             Din,
    input  logic             cnt_clr,
    output logic             det,
    output logic [CNT_W-1:0] match_cnt,
    output logic [3:0]       window,
    output logic [2:0]       state_o
);

    state_t state;
    state_t nxt;
    logic   hit;

    // Illegal encodings fall back to S0 even with en low
    always_comb begin
        nxt = state;
        case (state)
            S0:      if (en) nxt = Din ? S1    : S0;
            S1:      if (en) nxt = Din ? S1    : S10;
            S10:     if (en) nxt = Din ? S101  : S0;
            S101:    if (en) nxt = Din ? S1011 : S10;
            S1011:   if (en) nxt = Din ? S1    : S10;
            default: nxt = S0;
        endcase
        hit = en && (nxt == S1011);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state  <= S0;
            det    <= 1'b0;
            window <= 4'b0000;
        end else begin
            state <= nxt;
            det   <= hit;
            if (en) begin
                window <= {window[2:0], Din};
            end
        end
    end

    assign state_o = state;

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk (Clk),
        .rst (reset),
        .en  (en),
        .inc (hit),
        .clr (cnt_clr),
        .q   (match_cnt)
    );

endmodule

// File: tb/tb_bit_pattern_detector.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor
// compares both a default-width and a 2-bit-counter instance after each edge.
module tb_bit_pattern_detector;

    logic       Clk = 1'b0;
    logic       reset, en, Din, cnt_clr;
    logic       det, det2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    logic [3:0] window, window2;
    logic [2:0] state_o, state_o2;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        int         tgt;
        logic       det;
        int         cnt;
        logic [3:0] win;
        logic [2:0] st;
    } exp_t;

    exp_t q[$];

    always #5 Clk = ~Clk;

    bit_pattern_detector #(.CNT_W(8)) dut (
        .Clk(Clk), .reset(reset), .en(en), .Din(Din), .cnt_clr(cnt_clr),
        .det(det), .match_cnt(match_cnt), .window(window), .state_o(state_o)
    );

    bit_pattern_detector #(.CNT_W(2)) dut2 (
        .Clk(Clk), .reset(reset), .en(en), .Din(Din), .cnt_clr(cnt_clr),
        .det(det2), .match_cnt(match_cnt2), .window(window2), .state_o(state_o2)
    );

    always @(posedge Clk) edge_cnt++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, req);
        end
    endtask

    // Monitor: pops every expectation whose target edge has passed
    always @(posedge Clk) begin
        #2;
        while (q.size() > 0 && q[0].tgt <= edge_cnt) begin
            exp_t e;
            int   e2;
            e  = q.pop_front();
            e2 = (e.cnt > 3) ? 3 : e.cnt;
            chk("det",        int'(det),        int'(e.det));
            chk("match_cnt",  int'(match_cnt),  e.cnt);
            chk("window",     int'(window),     int'(e.win));
            chk("state_o",    int'(state_o),    int'(e.st));
            chk("det_w2",     int'(det2),       int'(e.det));
            chk("match_cnt2", int'(match_cnt2), e2);
        end
    end

    task automatic step(input logic r, input logic e, input logic d, input logic c,
                        input logic x_det, input int x_cnt, input logic [3:0] x_win,
                        input logic [2:0] x_st);
        exp_t ex;
        reset   = r;
        en      = e;
        Din     = d;
        cnt_clr = c;
        ex.tgt = edge_cnt + 1;
        ex.det = x_det;
        ex.cnt = x_cnt;
        ex.win = x_win;
        ex.st  = x_st;
        q.push_back(ex);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // reset state
        step(1, 1, 1, 1, 0, 0, 4'b0000, 3'd0);
        step(1, 0, 0, 0, 0, 0, 4'b0000, 3'd0);

        // single 1011, then en low holds everything and drops det
        step(0, 1, 1, 0, 0, 0, 4'b0001, 3'd1);
        step(0, 1, 0, 0, 0, 0, 4'b0010, 3'd2);
        step(0, 1, 1, 0, 0, 0, 4'b0101, 3'd3);
        step(0, 1, 1, 0, 1, 1, 4'b1011, 3'd4);
        step(0, 0, 0, 0, 0, 1, 4'b1011, 3'd4);

        // overlap 1011011
        step(1, 0, 0, 0, 0, 0, 4'b0000, 3'd0);
        step(0, 1, 1, 0, 0, 0, 4'b0001, 3'd1);
        step(0, 1, 0, 0, 0, 0, 4'b0010, 3'd2);
        step(0, 1, 1, 0, 0, 0, 4'b0101, 3'd3);
        step(0, 1, 1, 0, 1, 1, 4'b1011, 3'd4);
        step(0, 1, 0, 0, 0, 1, 4'b0110, 3'd2);
        step(0, 1, 1, 0, 0, 1, 4'b1101, 3'd3);
        step(0, 1, 1, 0, 1, 2, 4'b1011, 3'd4);

        // 101, three disabled cycles with toggling Din, then final 1
        step(1, 0, 0, 0, 0, 0, 4'b0000, 3'd0);
        step(0, 1, 1, 0, 0, 0, 4'b0001, 3'd1);
        step(0, 1, 0, 0, 0, 0, 4'b0010, 3'd2);
        step(0, 1, 1, 0, 0, 0, 4'b0101, 3'd3);
        step(0, 0, 1, 0, 0, 0, 4'b0101, 3'd3);
        step(0, 0, 0, 0, 0, 0, 4'b0101, 3'd3);
        step(0, 0, 1, 0, 0, 0, 4'b0101, 3'd3);
        step(0, 1, 1, 0, 1, 1, 4'b1011, 3'd4);
        step(0, 1, 0, 0, 0, 1, 4'b0110, 3'd2);

        // five back-to-back overlapping matches: 2-bit counter saturates at 3
        step(1, 0, 0, 0, 0, 0, 4'b0000, 3'd0);
        step(0, 1, 1, 0, 0, 0, 4'b0001, 3'd1);
        step(0, 1, 0, 0, 0, 0, 4'b0010, 3'd2);
        step(0, 1, 1, 0, 0, 0, 4'b0101, 3'd3);
        step(0, 1, 1, 0, 1, 1, 4'b1011, 3'd4);
        for (int k = 2; k <= 5; k++) begin
            step(0, 1, 0, 0, 0, k - 1, 4'b0110, 3'd2);
            step(0, 1, 1, 0, 0, k - 1, 4'b1101, 3'd3);
            step(0, 1, 1, 0, 1, k,     4'b1011, 3'd4);
        end

        // clear on a matching edge, then the next match counts from zero
        step(0, 1, 0, 0, 0, 5, 4'b0110, 3'd2);
        step(0, 1, 1, 0, 0, 5, 4'b1101, 3'd3);
        step(0, 1, 1, 1, 1, 0, 4'b1011, 3'd4);
        step(0, 1, 0, 0, 0, 0, 4'b0110, 3'd2);
        step(0, 1, 1, 0, 0, 0, 4'b1101, 3'd3);
        step(0, 1, 1, 0, 1, 1, 4'b1011, 3'd4);
        // clear still acts with en low
        step(0, 0, 1, 1, 0, 0, 4'b1011, 3'd4);

        // reset mid-pattern discards the partial 101
        step(1, 0, 0, 0, 0, 0, 4'b0000, 3'd0);
        step(0, 1, 1, 0, 0, 0, 4'b0001, 3'd1);
        step(0, 1, 0, 0, 0, 0, 4'b0010, 3'd2);
        step(0, 1, 1, 0, 0, 0, 4'b0101, 3'd3);
        step(1, 1, 1, 0, 0, 0, 4'b0000, 3'd0);
        step(0, 1, 1, 0, 0, 0, 4'b0001, 3'd1);
        step(0, 0, 0, 0, 0, 0, 4'b0001, 3'd1);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
